// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: ALU operation codes, opcodes, decode state and entry layout.
package rv_pkg;

    localparam logic [5:0] AluAdd   = 6'h00;
    localparam logic [5:0] AluSub   = 6'h01;
    localparam logic [5:0] AluSll   = 6'h02;
    localparam logic [5:0] AluSlt   = 6'h03;
    localparam logic [5:0] AluSltu  = 6'h04;
    localparam logic [5:0] AluXor   = 6'h05;
    localparam logic [5:0] AluSrl   = 6'h06;
    localparam logic [5:0] AluSra   = 6'h07;
    localparam logic [5:0] AluOr    = 6'h08;
    localparam logic [5:0] AluAnd   = 6'h09;
    localparam logic [5:0] AluAddi  = 6'h0A;
    localparam logic [5:0] AluSlti  = 6'h0B;
    localparam logic [5:0] AluSltiu = 6'h0C;
    localparam logic [5:0] AluXori  = 6'h0D;
    localparam logic [5:0] AluOri   = 6'h0E;
    localparam logic [5:0] AluAndi  = 6'h0F;
    localparam logic [5:0] AluSlli  = 6'h10;
    localparam logic [5:0] AluSrli  = 6'h11;
    localparam logic [5:0] AluSrai  = 6'h12;
    localparam logic [5:0] AluLb    = 6'h13;
    localparam logic [5:0] AluLh    = 6'h14;
    localparam logic [5:0] AluLw    = 6'h15;
    localparam logic [5:0] AluLbu   = 6'h16;
    localparam logic [5:0] AluLhu   = 6'h17;
    localparam logic [5:0] AluSb    = 6'h18;
    localparam logic [5:0] AluSh    = 6'h19;
    localparam logic [5:0] AluSw    = 6'h1A;
    localparam logic [5:0] AluBeq   = 6'h1B;
    localparam logic [5:0] AluBne   = 6'h1C;
    localparam logic [5:0] AluBlt   = 6'h1D;
    localparam logic [5:0] AluBge   = 6'h1E;
    localparam logic [5:0] AluBltu  = 6'h1F;
    localparam logic [5:0] AluBgeu  = 6'h20;
    localparam logic [5:0] AluLui   = 6'h21;
    localparam logic [5:0] AluAuipc = 6'h22;
    localparam logic [5:0] AluJal   = 6'h23;
    localparam logic [5:0] AluJalr  = 6'h24;

    localparam logic [6:0] OpcOp     = 7'h33;
    localparam logic [6:0] OpcOpImm  = 7'h13;
    localparam logic [6:0] OpcLoad   = 7'h03;
    localparam logic [6:0] OpcStore  = 7'h23;
    localparam logic [6:0] OpcBranch = 7'h63;
    localparam logic [6:0] OpcLui    = 7'h37;
    localparam logic [6:0] OpcAuipc  = 7'h17;
    localparam logic [6:0] OpcJal    = 7'h6F;
    localparam logic [6:0] OpcJalr   = 7'h67;

    typedef enum logic {StRun, StHalt} dec_state_e;

    typedef enum logic [2:0] {FmtNone, FmtI, FmtS, FmtB, FmtU, FmtJ, FmtShamt} imm_fmt_e;

    typedef struct packed {
        logic [5:0]  alu_control;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
    } dec_entry_t;

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational immediate generator: picks the instruction format and builds the
// sign-extended 32-bit immediate (shift-immediates yield a zero-extended shamt).
module rv_imm_gen
    import rv_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm,
    output imm_fmt_e    fmt
);

    always_comb begin
        case (instr[6:0])
            OpcOpImm:          fmt = (instr[13:12] == 2'b01) ? FmtShamt : FmtI;
            OpcLoad, OpcJalr:  fmt = FmtI;
            OpcStore:          fmt = FmtS;
            OpcBranch:         fmt = FmtB;
            OpcLui, OpcAuipc:  fmt = FmtU;
            OpcJal:            fmt = FmtJ;
            default:           fmt = FmtNone;
        endcase
    end

    always_comb begin
        case (fmt)
            FmtI:     imm = {{20{instr[31]}}, instr[31:20]};
            FmtShamt: imm = {27'b0, instr[24:20]};
            FmtS:     imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FmtB:     imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FmtU:     imm = {instr[31:12], 12'b0};
            FmtJ:     imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21],
                             1'b0};
            default:  imm = 32'b0;
        endcase
    end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage with valid/ready handshake, flush and optional illegal halt.
// Define RV_DECODE_ILLEGAL_EN to flag illegal instructions and halt until flush/reset.
module rv_decode_stage
    import rv_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      out_alu_control,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic            out_alu_src,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_illegal
);

    localparam dec_entry_t EntryRst = '{alu_control: 6'h00, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
                                        imm: 32'h0, pc: RESET_PC, alu_src: 1'b0,
                                        reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
                                        branch: 1'b0, jump: 1'b0};

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    imm_fmt_e    imm_fmt;
    logic        legal;
    logic        keep_rd;
    logic        accept;
    logic        run;
    logic        valid_q, valid_d;
    dec_entry_t  entry_q, entry_d;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    rv_imm_gen u_imm_gen (
        .instr (in_instr),
        .imm   (imm),
        .fmt   (imm_fmt)
    );

    always_comb begin
        entry_d           = EntryRst;
        entry_d.rs1       = in_instr[19:15];
        entry_d.rs2       = in_instr[24:20];
        entry_d.imm       = imm;
        entry_d.pc        = in_pc;
        legal             = 1'b1;
        keep_rd           = 1'b1;
        case (opcode)
            OpcOp: begin
                entry_d.reg_write = 1'b1;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'd0:    entry_d.alu_control = AluAdd;
                        3'd1:    entry_d.alu_control = AluSll;
                        3'd2:    entry_d.alu_control = AluSlt;
                        3'd3:    entry_d.alu_control = AluSltu;
                        3'd4:    entry_d.alu_control = AluXor;
                        3'd5:    entry_d.alu_control = AluSrl;
                        3'd6:    entry_d.alu_control = AluOr;
                        default: entry_d.alu_control = AluAnd;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'd0) begin
                    entry_d.alu_control = AluSub;
                end else if (funct7 == 7'b0100000 && funct3 == 3'd5) begin
                    entry_d.alu_control = AluSra;
                end else begin
                    legal = 1'b0;
                end
            end
            OpcOpImm: begin
                entry_d.reg_write = 1'b1;
                entry_d.alu_src   = 1'b1;
                case (funct3)
                    3'd0:    entry_d.alu_control = AluAddi;
                    3'd1:    entry_d.alu_control = AluSlli;
                    3'd2:    entry_d.alu_control = AluSlti;
                    3'd3:    entry_d.alu_control = AluSltiu;
                    3'd4:    entry_d.alu_control = AluXori;
                    3'd5:    entry_d.alu_control = in_instr[30] ? AluSrai : AluSrli;
                    3'd6:    entry_d.alu_control = AluOri;
                    default: entry_d.alu_control = AluAndi;
                endcase
                // Shift-immediates reuse the funct7 slot; only 0 or SRAI's 0100000 are valid.
                if (imm_fmt == FmtShamt &&
                    !(funct7 == 7'b0000000 || (funct3 == 3'd5 && funct7 == 7'b0100000))) begin
                    legal = 1'b0;
                end
            end
            OpcLoad: begin
                entry_d.reg_write = 1'b1;
                entry_d.mem_read  = 1'b1;
                entry_d.alu_src   = 1'b1;
                case (funct3)
                    3'd0:    entry_d.alu_control = AluLb;
                    3'd1:    entry_d.alu_control = AluLh;
                    3'd2:    entry_d.alu_control = AluLw;
                    3'd4:    entry_d.alu_control = AluLbu;
                    3'd5:    entry_d.alu_control = AluLhu;
                    default: legal = 1'b0;
                endcase
            end
            OpcStore: begin
                entry_d.mem_write = 1'b1;
                entry_d.alu_src   = 1'b1;
                keep_rd           = 1'b0;
                case (funct3)
                    3'd0:    entry_d.alu_control = AluSb;
                    3'd1:    entry_d.alu_control = AluSh;
                    3'd2:    entry_d.alu_control = AluSw;
                    default: legal = 1'b0;
                endcase
            end
            OpcBranch: begin
                entry_d.branch = 1'b1;
                keep_rd        = 1'b0;
                case (funct3)
                    3'd0:    entry_d.alu_control = AluBeq;
                    3'd1:    entry_d.alu_control = AluBne;
                    3'd4:    entry_d.alu_control = AluBlt;
                    3'd5:    entry_d.alu_control = AluBge;
                    3'd6:    entry_d.alu_control = AluBltu;
                    3'd7:    entry_d.alu_control = AluBgeu;
                    default: legal = 1'b0;
                endcase
            end
            OpcLui, OpcAuipc: begin
                entry_d.reg_write   = 1'b1;
                entry_d.alu_src     = 1'b1;
                entry_d.alu_control = (opcode == OpcLui) ? AluLui : AluAuipc;
            end
            OpcJal: begin
                entry_d.jump        = 1'b1;
                entry_d.reg_write   = 1'b1;
                entry_d.alu_control = AluJal;
            end
            OpcJalr: begin
                entry_d.jump        = 1'b1;
                entry_d.reg_write   = 1'b1;
                entry_d.alu_src     = 1'b1;
                entry_d.alu_control = AluJalr;
                legal               = (funct3 == 3'd0);
            end
            default: legal = 1'b0;
        endcase
        // Illegal encodings collapse to a NOP: ADD with every side effect disabled.
        if (!legal) begin
            entry_d.alu_control = AluAdd;
            entry_d.alu_src     = 1'b0;
            entry_d.reg_write   = 1'b0;
            entry_d.mem_read    = 1'b0;
            entry_d.mem_write   = 1'b0;
            entry_d.branch      = 1'b0;
            entry_d.jump        = 1'b0;
            keep_rd             = 1'b0;
        end
        entry_d.rd = keep_rd ? in_instr[11:7] : 5'd0;
    end

`ifdef RV_DECODE_ILLEGAL_EN
    dec_state_e state_q, state_d;
    logic       illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StRun;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                illegal_q <= !legal;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StRun;
        end else if (accept && !legal) begin
            state_d = StHalt;
        end
    end

    assign run         = (state_q == StRun);
    assign out_illegal = illegal_q;
`else
    assign run         = 1'b1;
    assign out_illegal = 1'b0;
`endif

    always_comb begin
        in_ready = run && (!valid_q || out_ready);
        accept   = in_valid && in_ready && !flush;
    end

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            entry_q <= EntryRst;
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                entry_q <= entry_d;
            end
        end
    end

    assign out_valid       = valid_q;
    assign out_alu_control = entry_q.alu_control;
    assign out_rs1         = entry_q.rs1;
    assign out_rs2         = entry_q.rs2;
    assign out_rd          = entry_q.rd;
    assign out_imm         = entry_q.imm;
    assign out_pc          = entry_q.pc;
    assign out_alu_src     = entry_q.alu_src;
    assign out_reg_write   = entry_q.reg_write;
    assign out_mem_read    = entry_q.mem_read;
    assign out_mem_write   = entry_q.mem_write;
    assign out_branch      = entry_q.branch;
    assign out_jump        = entry_q.jump;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed self-checking bench for rv_decode_stage; follows RV_DECODE_ILLEGAL_EN if defined.
module tb_rv_decode_stage;

    localparam logic [31:0] ResetPc = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_imm, out_pc;
    logic [5:0]  out_alu_control;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_alu_src, out_reg_write, out_mem_read, out_mem_write;
    logic        out_branch, out_jump, out_illegal;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rv_decode_stage #(
        .XLEN     (32),
        .RESET_PC (ResetPc)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instr        (in_instr),
        .in_pc           (in_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_alu_control (out_alu_control),
        .out_rs1         (out_rs1),
        .out_rs2         (out_rs2),
        .out_rd          (out_rd),
        .out_imm         (out_imm),
        .out_pc          (out_pc),
        .out_alu_src     (out_alu_src),
        .out_reg_write   (out_reg_write),
        .out_mem_read    (out_mem_read),
        .out_mem_write   (out_mem_write),
        .out_branch      (out_branch),
        .out_jump        (out_jump),
        .out_illegal     (out_illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_instr = instr;
        in_pc    = pc;
        in_valid = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        out_ready = 1'b1;
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pc", out_pc, ResetPc);
        check("rst_alu", 32'(out_alu_control), 32'h00);
        check("rst_illegal", 32'(out_illegal), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // addi x1,x0,5
        send(32'h0050_0093, 32'h100);
        step();
        check("addi_valid", 32'(out_valid), 32'd1);
        check("addi_alu", 32'(out_alu_control), 32'h0A);
        check("addi_rd", 32'(out_rd), 32'd1);
        check("addi_rs1", 32'(out_rs1), 32'd0);
        check("addi_imm", out_imm, 32'd5);
        check("addi_ctl", {26'd0, out_alu_src, out_reg_write, out_mem_read, out_mem_write,
                           out_branch, out_jump}, 32'b110000);
        check("addi_pc", out_pc, 32'h100);

        // sub x3,x1,x2
        send(32'h4020_81B3, 32'h104);
        step();
        check("sub_alu", 32'(out_alu_control), 32'h01);
        check("sub_regs", {17'd0, out_rs1, out_rs2, out_rd}, {17'd0, 5'd1, 5'd2, 5'd3});
        check("sub_ctl", {26'd0, out_alu_src, out_reg_write, out_mem_read, out_mem_write,
                          out_branch, out_jump}, 32'b010000);

        // beq x1,x2,-4
        send(32'hFE20_8EE3, 32'h108);
        step();
        check("beq_alu", 32'(out_alu_control), 32'h1B);
        check("beq_imm", out_imm, 32'hFFFF_FFFC);
        check("beq_rd", 32'(out_rd), 32'd0);
        check("beq_ctl", {26'd0, out_alu_src, out_reg_write, out_mem_read, out_mem_write,
                          out_branch, out_jump}, 32'b000010);

        // lui x5,0x12345 then stall three cycles with addi x2,x0,10 waiting
        send(32'h1234_52B7, 32'h10C);
        step();
        out_ready = 1'b0;
        send(32'h00A0_0113, 32'h110);
        #1;
        check("stall_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_alu", 32'(out_alu_control), 32'h21);
            check("stall_rd", 32'(out_rd), 32'd5);
            check("stall_imm", out_imm, 32'h1234_5000);
            check("stall_pc", out_pc, 32'h10C);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        step();
        check("nobubble_valid", 32'(out_valid), 32'd1);
        check("nobubble_alu", 32'(out_alu_control), 32'h0A);
        check("nobubble_rd", 32'(out_rd), 32'd2);
        check("nobubble_imm", out_imm, 32'd10);
        check("nobubble_pc", out_pc, 32'h110);

        // srai x1,x2,3
        send(32'h4031_5093, 32'h114);
        step();
        check("srai_alu", 32'(out_alu_control), 32'h12);
        check("srai_imm", out_imm, 32'd3);

        // sw x2,8(x1)
        send(32'h0020_A423, 32'h118);
        step();
        check("sw_alu", 32'(out_alu_control), 32'h1A);
        check("sw_imm", out_imm, 32'd8);
        check("sw_rd", 32'(out_rd), 32'd0);
        check("sw_ctl", {26'd0, out_alu_src, out_reg_write, out_mem_read, out_mem_write,
                         out_branch, out_jump}, 32'b100100);

        // consume without a new accept
        in_valid = 1'b0;
        step();
        check("drain_valid", 32'(out_valid), 32'd0);

        // flush together with an offered instruction drops it
        send(32'h0050_0093, 32'h11C);
        flush = 1'b1;
        step();
        check("flush_valid", 32'(out_valid), 32'd0);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        check("flush_dropped", 32'(out_valid), 32'd0);

        // all-ones word is not a valid instruction
        send(32'hFFFF_FFFF, 32'h120);
        step();
`ifdef RV_DECODE_ILLEGAL_EN
        check("ill_flag", 32'(out_illegal), 32'd1);
        check("ill_valid", 32'(out_valid), 32'd1);
        check("ill_alu", 32'(out_alu_control), 32'h00);
        check("ill_ctl", {26'd0, out_alu_src, out_reg_write, out_mem_read, out_mem_write,
                          out_branch, out_jump}, 32'b000000);
        check("ill_in_ready", 32'(in_ready), 32'd0);
        send(32'h0050_0093, 32'h124);
        step();
        check("halt_consumed", 32'(out_valid), 32'd0);
        check("halt_in_ready", 32'(in_ready), 32'd0);
        step();
        check("halt_no_accept", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check("unhalt_in_ready", 32'(in_ready), 32'd1);
`else
        check("nop_flag", 32'(out_illegal), 32'd0);
        check("nop_valid", 32'(out_valid), 32'd1);
        check("nop_alu", 32'(out_alu_control), 32'h00);
        check("nop_rd", 32'(out_rd), 32'd0);
        check("nop_ctl", {26'd0, out_alu_src, out_reg_write, out_mem_read, out_mem_write,
                          out_branch, out_jump}, 32'b000000);
        check("nop_in_ready", 32'(in_ready), 32'd1);
`endif
        send(32'h0050_0093, 32'h128);
        step();
        check("resume_valid", 32'(out_valid), 32'd1);
        check("resume_illegal", 32'(out_illegal), 32'd0);
        check("resume_pc", out_pc, 32'h128);

        // asynchronous reset with an entry held
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_pc", out_pc, ResetPc);
        check("arst_alu", 32'(out_alu_control), 32'h00);
        check("arst_reg_write", 32'(out_reg_write), 32'd0);
        check("arst_imm", out_imm, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rv_decode_stage.md
# rv_decode_stage

Registered instruction-decode stage feeding the ALU and the rest of the datapath. It accepts a 32-bit RV32I instruction and its PC over a valid/ready handshake, and decodes opcode/funct3/funct7 into the team's 6-bit ALU operation code. It also generates the sign-extended immediate and the datapath control bits. Results are held in a one-entry pipeline register with backpressure, flush and an illegal-instruction halt.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_PC, 32'h0000_0000, value driven on out_pc while out_valid is 0 after reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  discards the held entry; has priority over a new accept.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage can accept.
- in_instr  in  32  raw instruction.
- in_pc  in  32  PC of in_instr.
- out_valid  out  1  decoded entry present.
- out_ready  in  1  consumer takes the entry.
- out_alu_control  out  6  ALU operation code.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_imm  out  32  decoded immediate.
- out_pc  out  32  PC of the held entry.
- out_alu_src  out  1  1 means ALU B operand = out_imm.
- out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump  out  1 each  datapath controls.
- out_illegal  out  1  held entry is an undecodable instruction.

## Operation
- Reset: out_valid=0, out_illegal=0, all controls=0, out_alu_control=6'b000000, out_imm/out_rs*/out_rd=0, out_pc=RESET_PC, state=RUN.
- in_ready = (state==RUN) && (!out_valid || out_ready).
- Accept (in_valid && in_ready && !flush): the decode result is registered and out_valid=1 on the next edge.
- Consume without accept: out_valid goes to 0.
- flush: out_valid=0 next edge and state returns to RUN; any same-cycle input is dropped.
- ALU codes:
  - R-type: ADD..AND = 0x00..0x09.
  - I-type: ADDI..SRAI = 0x0A..0x12.
  - Loads: LB..LHU = 0x13..0x17.
  - Stores: SB..SW = 0x18..0x1A.
  - Branches: BEQ..BGEU = 0x1B..0x20.
  - LUI 0x21, AUIPC 0x22, JAL 0x23, JALR 0x24.
- SUB and SRA are selected by instr[30] with funct7 = 7'b0100000; any other nonzero funct7 on an R-type is illegal.
- Immediates: I, S, B (bit0=0), U (low 12 bits zero), J (bit0=0) are all sign-extended to 32 bits. SLLI/SRLI/SRAI produce imm = {27'b0, shamt}, because the ALU shifts by the full B operand.
- Controls:
  - R-type: reg_write=1, alu_src=0.
  - I-ALU: reg_write=1, alu_src=1.
  - Load: reg_write=1, mem_read=1, alu_src=1.
  - Store: mem_write=1, alu_src=1, rd forced to 0.
  - Branch: branch=1, alu_src=0, rd forced to 0.
  - JAL: jump=1, reg_write=1.
  - JALR: jump=1, reg_write=1, alu_src=1.
  - LUI/AUIPC: reg_write=1, alu_src=1.

## Timing
- Latency: 1 cycle from accept to out_valid. Full throughput (1 per cycle) while out_ready=1.
- in_ready is combinational from out_ready and state.
- While out_valid=1 and out_ready=0, every out_* signal is held stable.
- Simultaneous consume and accept: the new entry replaces the old one with no bubble.
- Deasserting rst_n mid-stream returns all outputs to reset values immediately; no partial entry survives.

## Configuration
- RV_DECODE_ILLEGAL_EN defined:
  - An illegal instruction is accepted with out_illegal=1, all controls=0 and out_alu_control=ADD.
  - State moves RUN→HALT on that accept, and in_ready=0 in HALT.
  - The illegal entry is still presented and consumed normally.
  - HALT exits only on flush or reset.
- Undefined:
  - No HALT state exists and out_illegal is tied to 0.
  - An illegal instruction decodes as a NOP (ADD, all controls=0, rd=0) and the stream continues.

## Structure
- Shared package rv_pkg holds:
  - the 6-bit ALU code constants (single source, also imported by the ALU);
  - the opcode constants (7'h33, 13, 03, 23, 63, 37, 17, 6F, 67);
  - the RUN/HALT state enum.
- One sub-module, rv_imm_gen: combinational, takes instr and produces the immediate plus a format select.
- Decode logic, pipeline register and state logic live in rv_decode_stage.

## Test plan
- 0x00500093 (addi x1,x0,5), out_ready=1 → next cycle: out_valid=1, alu_control=0x0A, rd=1, rs1=0, imm=5, alu_src=1, reg_write=1.
- 0x402081B3 (sub x3,x1,x2) → alu_control=0x01, rs1=1, rs2=2, rd=3, alu_src=0.
- 0xFE208EE3 (beq x1,x2,-4) → alu_control=0x1B, imm=0xFFFFFFFC, branch=1, reg_write=0.
- 0x123452B7 (lui x5,0x12345) with out_ready=0 held 3 cycles → entry stable, in_ready=0. Release together with a new in_valid → the new entry follows with no bubble.
- 0xFFFFFFFF with macro on → out_illegal=1, in_ready stays 0 until a flush pulse, then back to RUN. With macro off → NOP decode and in_ready=1.
- flush asserted in the same cycle as in_valid → out_valid=0 next edge and the instruction is dropped.
